// File: rtl/alu_reservation_station.sv
// alu_reservation_station
//   Reservation station in front of the ALU. Holds dispatched ALU
//   instructions until both operands are available. While they wait, it
//   watches the common data bus (CDB) for the tags of pending operands, and
//   it issues one ready instruction per cycle over a valid/ready handshake.
//
// Configuration macro: RS_AGE_PRIORITY_EN
//   defined   -> issue the oldest ready entry (per-entry saturating age)
//   undefined -> issue the lowest-index ready entry (no age state)
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              synchronous squash of every entry and of the issue lock
//   dispatch_*         incoming instruction; dispatch_ready means a free entry exists
//   cdb_valid/tag/data result broadcast snooped for pending operands
//   alu_valid/ready    issue handshake towards the ALU
//   alu_a/b/funct3/sign/dest_tag  issued payload, all zero while alu_valid=0
//
// Every output is a register. The next state of the entries is built
// combinationally, the issue choice is made from that next state, and the
// result is registered. The effect is the same as selecting from registered
// entry readiness, and no CDB value reaches an output in the cycle it is
// broadcast.
module alu_reservation_station #(
    parameter int XLEN      = 32,
    parameter int RS_SIZE   = 4,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 dispatch_valid,
    output logic                 dispatch_ready,
    input  logic [2:0]           dispatch_funct3,
    input  logic                 dispatch_sign,
    input  logic                 dispatch_q1_pend,
    input  logic [TAG_WIDTH-1:0] dispatch_q1_tag,
    input  logic [XLEN-1:0]      dispatch_v1,
    input  logic                 dispatch_q2_pend,
    input  logic [TAG_WIDTH-1:0] dispatch_q2_tag,
    input  logic [XLEN-1:0]      dispatch_v2,
    input  logic [TAG_WIDTH-1:0] dispatch_dest,
    input  logic                 cdb_valid,
    input  logic [TAG_WIDTH-1:0] cdb_tag,
    input  logic [XLEN-1:0]      cdb_data,
    output logic                 alu_valid,
    input  logic                 alu_ready,
    output logic [XLEN-1:0]      alu_a,
    output logic [XLEN-1:0]      alu_b,
    output logic [2:0]           alu_funct3,
    output logic                 alu_sign,
    output logic [TAG_WIDTH-1:0] alu_dest_tag
);

    localparam int IW = $clog2(RS_SIZE);

    typedef struct packed {
        logic                 busy;
        logic [2:0]           funct3;
        logic                 sign;
        logic [TAG_WIDTH-1:0] dest;
        logic                 q1_pend;
        logic [TAG_WIDTH-1:0] q1_tag;
        logic [XLEN-1:0]      v1;
        logic                 q2_pend;
        logic [TAG_WIDTH-1:0] q2_tag;
        logic [XLEN-1:0]      v2;
    } entry_t;

    entry_t               ent_r [RS_SIZE];
    entry_t               ent_s [RS_SIZE];
    logic                 alu_valid_r;
    logic [IW-1:0]        sel_r;
    logic                 dispatch_ready_r;
    logic [XLEN-1:0]      alu_a_r;
    logic [XLEN-1:0]      alu_b_r;
    logic [2:0]           alu_funct3_r;
    logic                 alu_sign_r;
    logic [TAG_WIDTH-1:0] alu_dest_tag_r;

    logic                 handshake_s;
    logic                 accept_s;
    logic                 lock_s;
    logic                 valid_s;
    logic                 pick_found_s;
    logic [IW-1:0]        pick_idx_s;
    logic [IW-1:0]        free_idx_s;
    logic [IW-1:0]        sel_s;
    logic [RS_SIZE-1:0]   ready_s;
    logic [RS_SIZE-1:0]   busy_s;
    entry_t               sel_ent_s;

`ifdef RS_AGE_PRIORITY_EN
    logic [IW-1:0]        age_r [RS_SIZE];
    logic [IW-1:0]        age_s [RS_SIZE];
`endif

    // True when a pending operand is being produced on the bus right now.
    function automatic logic tag_hit(input logic pend, input logic [TAG_WIDTH-1:0] tag,
                                     input logic bus_valid, input logic [TAG_WIDTH-1:0] bus_tag);
        return pend && bus_valid && (tag == bus_tag);
    endfunction

    // Lowest-index free entry. The scan runs downward so that the last write wins.
    always_comb begin
        free_idx_s = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!ent_r[i].busy) free_idx_s = IW'(i);
            else                free_idx_s = free_idx_s;
        end
    end

    // Next state of every entry: snoop, issue free, dispatch write, flush.
    always_comb begin
        ent_s       = ent_r;
        handshake_s = alu_valid_r && alu_ready;
        // The entry freed by this cycle's issue is not offered for dispatch until the next cycle.
        accept_s    = dispatch_valid && dispatch_ready_r && !flush;
        ready_s     = '0;
        busy_s      = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ent_r[i].busy && tag_hit(ent_r[i].q1_pend, ent_r[i].q1_tag, cdb_valid, cdb_tag)) begin
                ent_s[i].q1_pend = 1'b0;
                ent_s[i].v1      = cdb_data;
            end else begin
                ent_s[i].q1_pend = ent_r[i].q1_pend;
            end
            if (ent_r[i].busy && tag_hit(ent_r[i].q2_pend, ent_r[i].q2_tag, cdb_valid, cdb_tag)) begin
                ent_s[i].q2_pend = 1'b0;
                ent_s[i].v2      = cdb_data;
            end else begin
                ent_s[i].q2_pend = ent_s[i].q2_pend;
            end
            if (handshake_s && (IW'(i) == sel_r)) ent_s[i].busy = 1'b0;
            else                                  ent_s[i].busy = ent_s[i].busy;
            if (accept_s && (IW'(i) == free_idx_s)) begin
                ent_s[i].busy    = 1'b1;
                ent_s[i].funct3  = dispatch_funct3;
                ent_s[i].sign    = dispatch_sign;
                ent_s[i].dest    = dispatch_dest;
                ent_s[i].q1_tag  = dispatch_q1_tag;
                ent_s[i].q2_tag  = dispatch_q2_tag;
                // A pending operand that is broadcast in the dispatch cycle is taken from the bus.
                ent_s[i].q1_pend = dispatch_q1_pend &&
                                   !tag_hit(dispatch_q1_pend, dispatch_q1_tag, cdb_valid, cdb_tag);
                ent_s[i].v1      = tag_hit(dispatch_q1_pend, dispatch_q1_tag, cdb_valid, cdb_tag)
                                   ? cdb_data : dispatch_v1;
                ent_s[i].q2_pend = dispatch_q2_pend &&
                                   !tag_hit(dispatch_q2_pend, dispatch_q2_tag, cdb_valid, cdb_tag);
                ent_s[i].v2      = tag_hit(dispatch_q2_pend, dispatch_q2_tag, cdb_valid, cdb_tag)
                                   ? cdb_data : dispatch_v2;
            end else begin
                ent_s[i].busy = ent_s[i].busy;
            end
            if (flush) ent_s[i].busy = 1'b0;
            else       ent_s[i].busy = ent_s[i].busy;
            busy_s[i]  = ent_s[i].busy;
            ready_s[i] = ent_s[i].busy && !ent_s[i].q1_pend && !ent_s[i].q2_pend;
        end
    end

`ifdef RS_AGE_PRIORITY_EN
    // Age bookkeeping. A new entry starts at zero and older busy entries age on each accepted dispatch.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            age_s[i] = age_r[i];
            if (accept_s && (IW'(i) == free_idx_s))                     age_s[i] = {IW{1'b0}};
            else if (accept_s && ent_r[i].busy && (age_r[i] != {IW{1'b1}})) age_s[i] = age_r[i] + {{(IW-1){1'b0}}, 1'b1};
            else                                                        age_s[i] = age_r[i];
        end
    end

    // Oldest ready entry. The strict compare favours the lower index if two ages ever match.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ready_s[i] && (!pick_found_s || (age_s[i] > age_s[pick_idx_s]))) begin
                pick_found_s = 1'b1;
                pick_idx_s   = IW'(i);
            end else begin
                pick_idx_s   = pick_idx_s;
            end
        end
    end
`else
    // Lowest-index ready entry. The scan runs downward so that the last write wins.
    always_comb begin
        pick_found_s = |ready_s;
        pick_idx_s   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready_s[i]) pick_idx_s = IW'(i);
            else            pick_idx_s = pick_idx_s;
        end
    end
`endif

    // Issue choice. A stalled offer keeps its entry, so the payload cannot change.
    always_comb begin
        lock_s    = alu_valid_r && !alu_ready && !flush;
        sel_s     = lock_s ? sel_r : pick_idx_s;
        valid_s   = lock_s || pick_found_s;
        sel_ent_s = ent_s[sel_s];
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_r[i] <= '0;
`ifdef RS_AGE_PRIORITY_EN
                age_r[i] <= '0;
`endif
            end
            alu_valid_r      <= 1'b0;
            sel_r            <= '0;
            dispatch_ready_r <= 1'b1;
            alu_a_r          <= '0;
            alu_b_r          <= '0;
            alu_funct3_r     <= 3'b000;
            alu_sign_r       <= 1'b0;
            alu_dest_tag_r   <= '0;
        end else begin
            ent_r            <= ent_s;
`ifdef RS_AGE_PRIORITY_EN
            age_r            <= age_s;
`endif
            alu_valid_r      <= valid_s;
            sel_r            <= sel_s;
            dispatch_ready_r <= !(&busy_s);
            alu_a_r          <= valid_s ? sel_ent_s.v1     : '0;
            alu_b_r          <= valid_s ? sel_ent_s.v2     : '0;
            alu_funct3_r     <= valid_s ? sel_ent_s.funct3 : 3'b000;
            alu_sign_r       <= valid_s ? sel_ent_s.sign   : 1'b0;
            alu_dest_tag_r   <= valid_s ? sel_ent_s.dest   : '0;
        end
    end

    assign dispatch_ready = dispatch_ready_r;
    assign alu_valid      = alu_valid_r;
    assign alu_a          = alu_a_r;
    assign alu_b          = alu_b_r;
    assign alu_funct3     = alu_funct3_r;
    assign alu_sign       = alu_sign_r;
    assign alu_dest_tag   = alu_dest_tag_r;

endmodule
